// File: rtl/hamming_uart_tx.sv
// SECDED (13,8) Hamming encoder feeding a UART serialiser: start bit,
// 13 codeword bits LSB first, then STOP_BITS stop bits.
module hamming_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx,
    output logic        busy,
    output logic [12:0] codeword,
    output logic [15:0] frames_sent
);

    localparam int unsigned   BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic [3:0]    bit_next;
    logic          stop_cnt;
    logic          baud_end;
    logic [12:0]   enc;

    // Bit index equals Hamming position; bit 0 makes the whole word even parity.
    function automatic logic [12:0] encode(input logic [7:0] d);
        logic [12:0] c;
        c      = '0;
        c[3]   = d[0];
        c[5]   = d[1];
        c[6]   = d[2];
        c[7]   = d[3];
        c[9]   = d[4];
        c[10]  = d[5];
        c[11]  = d[6];
        c[12]  = d[7];
        c[1]   = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        c[2]   = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        c[4]   = d[1] ^ d[2] ^ d[3] ^ d[7];
        c[8]   = d[4] ^ d[5] ^ d[6] ^ d[7];
        c[0]   = ^c[12:1];
        return c;
    endfunction

    always_comb begin
        enc      = encode(tx_data);
        baud_end = (baud_cnt == BAUD_LAST);
        bit_next = bit_idx + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            stop_cnt    <= '0;
            tx          <= 1'b1;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            codeword    <= '0;
            frames_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_valid) begin
                        codeword <= enc;
                        state    <= START;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= codeword[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 4'd12) begin
                            state    <= STOP;
                            stop_cnt <= '0;
                            tx       <= 1'b1;
                        end else begin
                            bit_idx <= bit_next;
                            tx      <= codeword[bit_next];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            state       <= IDLE;
                            stop_cnt    <= '0;
                            busy        <= 1'b0;
                            tx_ready    <= 1'b1;
                            frames_sent <= frames_sent + 16'd1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
